// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: BLANK/SHOW slot sequencer per digit,
// with a double-buffered (pending -> shadow) display image swapped only at frame wrap.
module seg_scan_ctrl #(
  parameter int N_DIG       = 8,
  parameter int ON_TICKS    = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic [4*N_DIG-1:0] DATA,
  input  logic [N_DIG-1:0]   DP,
  input  logic [N_DIG-1:0]   EN_MASK,
  input  logic               LOAD,
  output logic [N_DIG-1:0]   AN,
  output logic [6:0]         SEG,
  output logic               SEG_DP,
  output logic               LOAD_ACK,
  output logic               FRAME_DONE
);

  localparam int                IDX_W      = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_DIG - 1);
  localparam logic [7:0]        ON_LAST    = 8'(ON_TICKS - 1);
  localparam logic [7:0]        BLANK_LAST = (BLANK_TICKS > 0) ? 8'(BLANK_TICKS - 1) : 8'd0;
  localparam bit                SKIP_BLANK = (BLANK_TICKS == 0);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         tick_q, tick_d;
  logic               wrap;

  logic [4*N_DIG-1:0] sh_data_q, sh_data_d;
  logic [N_DIG-1:0]   sh_dp_q, sh_dp_d;
  logic [N_DIG-1:0]   sh_en_q, sh_en_d;
  logic [4*N_DIG-1:0] pend_data_q, pend_data_d;
  logic [N_DIG-1:0]   pend_dp_q, pend_dp_d;
  logic [N_DIG-1:0]   pend_en_q, pend_en_d;
  logic               pend_flag_q, pend_flag_d;

  logic [N_DIG-1:0]   an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               seg_dp_q, seg_dp_d;
  logic               load_ack_q, load_ack_d;
  logic               frame_done_q, frame_done_d;

  logic [3:0]         nib_sel;
  logic               dp_sel;
  logic               en_sel;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot sequencer: every digit owns a BLANK+SHOW slot whether enabled or not.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    wrap    = 1'b0;
    if (CE) begin
      case (state_q)
        ST_BLANK: begin
          if (SKIP_BLANK || tick_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            tick_d  = 8'd0;
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
        ST_SHOW: begin
          if (tick_q == ON_LAST) begin
            tick_d  = 8'd0;
            state_d = SKIP_BLANK ? ST_SHOW : ST_BLANK;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end
  end

  // The swap reads pending as held before this edge, so a coincident LOAD waits a frame.
  always_comb begin
    sh_data_d    = sh_data_q;
    sh_dp_d      = sh_dp_q;
    sh_en_d      = sh_en_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_flag_d  = pend_flag_q;
    load_ack_d   = 1'b0;
    frame_done_d = wrap;
    if (wrap && pend_flag_q) begin
      sh_data_d   = pend_data_q;
      sh_dp_d     = pend_dp_q;
      sh_en_d     = pend_en_q;
      pend_flag_d = 1'b0;
      load_ack_d  = 1'b1;
    end
    if (LOAD) begin
      pend_data_d = DATA;
      pend_dp_d   = DP;
      pend_en_d   = EN_MASK;
      pend_flag_d = 1'b1;
    end
  end

  always_comb begin
    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    en_sel  = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_sel = sh_data_q[4*i +: 4];
        dp_sel  = sh_dp_q[i];
        en_sel  = sh_en_q[i];
      end
    end
  end

  always_comb begin
    an_d     = '1;
    seg_d    = 7'h7F;
    seg_dp_d = 1'b1;
    if (state_q == ST_SHOW) begin
      seg_d    = hex_to_seg(nib_sel);
      seg_dp_d = ~(dp_sel & en_sel);
      for (int i = 0; i < N_DIG; i++) begin
        an_d[i] = ~(en_sel && (idx_q == IDX_W'(i)));
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      tick_q       <= 8'd0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_en_q      <= '0;
      pend_flag_q  <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      seg_dp_q     <= 1'b1;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tick_q       <= tick_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_en_q      <= sh_en_d;
      pend_flag_q  <= pend_flag_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pending content is only meaningful while pend_flag_q is set.
  always_ff @(posedge CLK) begin
    pend_data_q <= pend_data_d;
    pend_dp_q   <= pend_dp_d;
    pend_en_q   <= pend_en_d;
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign SEG_DP     = seg_dp_q;
  assign LOAD_ACK   = load_ack_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: per-CE scoreboard on a 4-digit ON=1/BLANK=1 instance,
// plus a 4-digit ON=2/BLANK=0 instance scanned with CE held high.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce, load, ce2, load2;
  logic [15:0] data, data2;
  logic [3:0]  dp, en, dp2, en2;
  logic [3:0]  an, an2;
  logic [6:0]  seg, seg2;
  logic        seg_dp, seg_dp2, ack, ack2, fd, fd2;

  seg_scan_ctrl #(.N_DIG(4), .ON_TICKS(1), .BLANK_TICKS(1)) u_dut (
    .CLK(clk), .RST(rst), .CE(ce), .DATA(data), .DP(dp), .EN_MASK(en), .LOAD(load),
    .AN(an), .SEG(seg), .SEG_DP(seg_dp), .LOAD_ACK(ack), .FRAME_DONE(fd)
  );

  seg_scan_ctrl #(.N_DIG(4), .ON_TICKS(2), .BLANK_TICKS(0)) u_dut2 (
    .CLK(clk), .RST(rst), .CE(ce2), .DATA(data2), .DP(dp2), .EN_MASK(en2), .LOAD(load2),
    .AN(an2), .SEG(seg2), .SEG_DP(seg_dp2), .LOAD_ACK(ack2), .FRAME_DONE(fd2)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       ack;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       sb2_q[$];
  int         n_chk = 0;
  int         n_bad = 0;
  int         ack_seen = 0;
  int         fd_seen = 0;
  logic [6:0] dec_tab [16];

  always @(posedge clk) begin
    if (ack) ack_seen <= ack_seen + 1;
    if (fd)  fd_seen  <= fd_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slot k of a frame: even k shows digit k/2, odd k is blank; wrap flags on the last CE.
  task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m,
                            input logic a, input int nslot);
    for (int k = 0; k < nslot; k++) begin
      exp_t e;
      int   g;
      g = k / 2;
      if (k % 2 == 0) begin
        e.an  = m[g] ? ~(4'b0001 << g) : 4'hF;
        e.seg = dec_tab[d[4*g +: 4]];
        e.dp  = ~(p[g] & m[g]);
      end else begin
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
      end
      e.fd  = (k == 7);
      e.ack = (k == 7) && a;
      sb_q.push_back(e);
    end
  endtask

  task automatic ce_step(input logic ld);
    exp_t e;
    @(negedge clk);
    ce   = 1'b1;
    load = ld;
    @(posedge clk);
    #1;
    ce   = 1'b0;
    load = 1'b0;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_bad++;
      $display("FAIL sb_underflow: got=empty exp=entry at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      chk("frame_done", 32'(fd), 32'(e.fd));
      chk("load_ack", 32'(ack), 32'(e.ack));
      @(posedge clk);
      #1;
      chk("an", 32'(an), 32'(e.an));
      chk("seg", 32'(seg), 32'(e.seg));
      chk("seg_dp", 32'(seg_dp), 32'(e.dp));
    end
    repeat (8) @(posedge clk);
  endtask

  task automatic run_ces(input int n);
    for (int i = 0; i < n; i++) ce_step(1'b0);
  endtask

  task automatic set_ld(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m);
    data = d;
    dp   = p;
    en   = m;
  endtask

  task automatic do_load();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst = 1'b1; ce = 1'b0; load = 1'b0; ce2 = 1'b0; load2 = 1'b0;
    data = '0; dp = '0; en = '0; data2 = '0; dp2 = '0; en2 = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(seg_dp), 32'h1);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_fd", 32'(fd), 32'h0);
    chk("rst_an2", 32'(an2), 32'hF);
    @(negedge clk);
    rst = 1'b0;

    // Basic load: first frame still shows the zeroed shadow, swap at its wrap.
    set_ld(16'h3210, 4'h0, 4'hF);
    do_load();
    push_frame(16'h0000, 4'h0, 4'h0, 1'b1, 8);
    run_ces(8);
    push_frame(16'h3210, 4'h0, 4'hF, 1'b0, 8);
    run_ces(8);

    // Masked digits keep their slots.
    set_ld(16'h5678, 4'b0011, 4'b0101);
    do_load();
    push_frame(16'h3210, 4'h0, 4'hF, 1'b1, 8);
    run_ces(8);
    push_frame(16'h5678, 4'b0011, 4'b0101, 1'b0, 8);
    run_ces(8);

    // Two loads in one frame collapse into one acknowledge.
    push_frame(16'h5678, 4'b0011, 4'b0101, 1'b1, 8);
    run_ces(2);
    set_ld(16'h1111, 4'h0, 4'hF);
    do_load();
    run_ces(3);
    set_ld(16'h2222, 4'h0, 4'hF);
    do_load();
    run_ces(3);
    push_frame(16'h2222, 4'h0, 4'hF, 1'b0, 8);
    run_ces(8);

    // Load on the wrap edge with nothing pending is deferred one frame.
    set_ld(16'hABCD, 4'h0, 4'hF);
    push_frame(16'h2222, 4'h0, 4'hF, 1'b0, 8);
    run_ces(7);
    ce_step(1'b1);
    push_frame(16'h2222, 4'h0, 4'hF, 1'b1, 8);
    run_ces(8);
    push_frame(16'hABCD, 4'h0, 4'hF, 1'b0, 8);
    run_ces(8);
    #1;
    chk("ack_count", 32'(ack_seen), 32'd4);
    chk("fd_count", 32'(fd_seen), 32'd9);

    // Reset mid-frame at digit 2 with a load pending.
    set_ld(16'h9999, 4'h0, 4'hF);
    do_load();
    push_frame(16'hABCD, 4'h0, 4'hF, 1'b0, 5);
    run_ces(5);
    #3;
    rst = 1'b1;
    ce  = 1'b1;
    #1;
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_dp", 32'(seg_dp), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_an", 32'(an), 32'hF);
    chk("rst_hold_seg", 32'(seg), 32'h7F);
    chk("rst_hold_ack", 32'(ack), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ce  = 1'b0;
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0, 8);
    run_ces(8);
    #1;
    chk("ack_count_post_rst", 32'(ack_seen), 32'd4);
    chk("fd_count_post_rst", 32'(fd_seen), 32'd10);

    // No-blank instance with CE held high.
    data2 = 16'h4321;
    dp2   = 4'b1000;
    en2   = 4'hF;
    @(negedge clk);
    load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    ce2   = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (fd2) found = 1'b1;
    end
    chk("fd2_seen", 32'(found), 32'h1);
    if (found) begin
      chk("ack2", 32'(ack2), 32'h1);
      for (int j = 0; j < 16; j++) begin
        exp_t e;
        int   g;
        g     = (j / 2) % 4;
        e.an  = ~(4'b0001 << g);
        e.seg = dec_tab[data2[4*g +: 4]];
        e.dp  = ~dp2[g];
        e.fd  = (j % 8 == 7);
        e.ack = 1'b0;
        sb2_q.push_back(e);
      end
      while (sb2_q.size() > 0) begin
        exp_t e;
        e = sb2_q.pop_front();
        @(posedge clk);
        #1;
        chk("an2", 32'(an2), 32'(e.an));
        chk("seg2", 32'(seg2), 32'(e.seg));
        chk("seg_dp2", 32'(seg_dp2), 32'(e.dp));
        chk("fd2", 32'(fd2), 32'(e.fd));
      end
    end
    ce2 = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter N_DIG, default 8: number of multiplexed digits, range 2..8.
REQ-002 Parameter ON_TICKS, default 4: CE periods each digit is lit, range 1..255.
REQ-003 Parameter BLANK_TICKS, default 1: CE periods all anodes are off before each digit is lit, range 0..255.
REQ-004 CLK  in  1  system clock; all logic on the rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 CE  in  1  one-CLK scan tick (1 kHz divider output); the block SHALL ignore CE whenever RST is high.
REQ-007 DATA  in  4*N_DIG  hex nibble per digit; digit i is DATA[4i+3:4i].
REQ-008 DP  in  N_DIG  decimal point request per digit, 1 = lit.
REQ-009 EN_MASK  in  N_DIG  digit enable, 1 = digit may light.
REQ-010 LOAD  in  1  one-CLK strobe capturing DATA/DP/EN_MASK into the pending buffer.
REQ-011 AN  out  N_DIG  anode drive, active-low, registered.
REQ-012 SEG  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-013 SEG_DP  out  1  decimal point, active-low, registered.
REQ-014 LOAD_ACK  out  1  one-CLK pulse when pending content is moved to the display registers.
REQ-015 FRAME_DONE  out  1  one-CLK pulse at each digit-index wrap N_DIG-1 -> 0.

Function
REQ-016 Two states: BLANK and SHOW; a tick counter of ON_TICKS/BLANK_TICKS range and a digit index 0..N_DIG-1; all advance only on CLK edges with CE=1.
REQ-017 BLANK: AN all ones, SEG all ones, SEG_DP 1; after BLANK_TICKS CEs -> SHOW with tick counter cleared; BLANK_TICKS=0 SHALL skip BLANK entirely.
REQ-018 SHOW: AN bit [index] = 0 only if shadow EN_MASK[index]=1, else AN all ones; SEG = hex decode of shadow nibble [index]; SEG_DP = ~shadow DP[index] gated by enable.
REQ-019 After ON_TICKS CEs in SHOW: index increments (N_DIG-1 wraps to 0), state -> BLANK (or SHOW of next digit if BLANK_TICKS=0).
REQ-020 Disabled digits SHALL still consume their full slot, keeping frame period = N_DIG*(ON_TICKS+BLANK_TICKS) CEs.
REQ-021 AN/SEG/SEG_DP SHALL reflect a state change on the CLK edge following the CE edge that caused it (1-CLK latency).
REQ-022 Hex decode, active-low: 0->7'h40, 1->7'h79, 2->7'h24, 3->7'h30, 4->7'h19, 5->7'h12, 6->7'h02, 7->7'h78, 8->7'h00, 9->7'h10, A->7'h08, b->7'h03, C->7'h46, d->7'h21, E->7'h06, F->7'h0E.
REQ-023 LOAD=1 SHALL capture DATA/DP/EN_MASK into pending and set a pending flag; LOAD while pending already set overwrites pending, yields one ACK only.
REQ-024 On the wrap edge (REQ-019 with index N_DIG-1): FRAME_DONE=1 for one CLK; if pending flag set, shadow <= pending, flag cleared, LOAD_ACK=1 same cycle.
REQ-025 LOAD coincident with the wrap edge: transfer uses pending content held before that edge; the new capture stays pending for the next frame; if no prior pending, no transfer and no ACK this frame.
REQ-026 Shadow registers SHALL never change except at REQ-024, so a displayed frame is never torn.

Reset
REQ-027 RST high: state BLANK, index 0, tick counter 0, AN all ones, SEG 7'h7F, SEG_DP 1, shadow DATA/DP/EN_MASK 0, pending flag 0, LOAD_ACK 0, FRAME_DONE 0.
REQ-028 RST asserted mid-frame or mid-pending SHALL discard pending content without ACK; after release, scanning restarts at digit 0 in BLANK on the next CE.

Verification
REQ-029 N_DIG=4, ON=1, BLANK=1, LOAD DATA=16'h3210, EN=4'hF, CE every 10 CLK -> FRAME_DONE/LOAD_ACK after 8 CEs; next frame AN sequence E,F,D,F,B,F,7,F with SEG 40,79,24,30.
REQ-030 EN_MASK=4'b0101 -> AN never drives digits 1,3; frame period still 8 CEs.
REQ-031 Two LOADs (16'h1111 then 16'h2222) in one frame -> single LOAD_ACK at wrap, next frame shows 2222.
REQ-032 LOAD 16'hABCD on the exact wrap CLK with no prior pending -> no ACK at that wrap; ACK and display of ABCD at the following wrap.
REQ-033 RST pulse while index=2 and pending set -> outputs at reset values, no LOAD_ACK; first CE after release enters SHOW digit 0 after BLANK_TICKS.
REQ-034 BLANK_TICKS=0, CE held high -> digit advances every ON_TICKS CLKs, AN never all ones while any digit enabled.
